// File: rtl/sram_arbiter_nx1.sv
// N-to-1 round-robin arbiter merging SRAM-like masters onto one slave port.
// Responses are routed back in acceptance order via a small grant-index FIFO.
module sram_arbiter_nx1 #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUTST  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_MST-1:0]          m_req,
    input  logic [N_MST-1:0]          m_wr,
    input  logic [2*N_MST-1:0]        m_size,
    input  logic [ADDR_W*N_MST-1:0]   m_addr,
    input  logic [DATA_W*N_MST-1:0]   m_wdata,
    output logic [N_MST-1:0]          m_addr_ok,
    output logic [N_MST-1:0]          m_data_ok,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      s_req,
    output logic                      s_wr,
    output logic [1:0]                s_size,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic                      s_addr_ok,
    input  logic                      s_data_ok,
    input  logic [DATA_W-1:0]         s_rdata,
    output logic [$clog2(OUTST):0]    outst_cnt,
    output logic                      proto_err
);

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int CNT_W = $clog2(OUTST) + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] fifo [OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;
    logic             stray;
    logic             found;
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_MST - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(OUTST - 1)) ? '0 : v + 1'b1;
    endfunction

    // First requester at or after rr_ptr; a pending lock freezes the choice.
    always_comb begin
        grant    = rr_ptr;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (lock) begin
            grant = lock_idx;
        end else begin
            for (int unsigned i = 0; i < N_MST; i++) begin
                cand = int'(rr_ptr) + i;
                if (cand >= N_MST) cand = cand - N_MST;
                cand_idx = IDX_W'(cand);
                if (!found && m_req[cand_idx]) begin
                    grant = cand_idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int unsigned i = 0; i < N_MST; i++) begin
            if (grant == IDX_W'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[ADDR_W*i +: ADDR_W];
                s_wdata = m_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign full   = (cnt == CNT_W'(OUTST));
    assign empty  = (cnt == '0);
    assign head   = fifo[rd_ptr];
    // Full blocks the request even when a pop lands in the same cycle.
    assign s_req  = resetn & m_req[grant] & ~full;
    assign accept = s_req & s_addr_ok;
    assign pop    = resetn & s_data_ok & ~empty;
    assign stray  = resetn & s_data_ok & empty;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (accept) m_addr_ok[grant] = 1'b1;
        if (pop)    m_data_ok[head]  = 1'b1;
    end

    assign m_rdata   = s_rdata;
    assign outst_cnt = cnt;

    always_ff @(posedge clk) begin
        if (accept) fifo[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= idx_inc(grant);
                lock   <= 1'b0;
            end else if (s_req) begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (stray) proto_err <= 1'b1;
        end
    end

endmodule
